// File: rtl/finger_button_debounce.sv
// Finger-pad input conditioning: two-flop synchronizer plus an independent debouncer per pad,
// producing a clean level and registered one-cycle press/release pulses.
module finger_button_debounce #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               C,
  input  logic               CLR,
  input  logic [NUM_BTN-1:0] BTN_RAW,
  output logic [NUM_BTN-1:0] BTN_LEVEL,
  output logic [NUM_BTN-1:0] PRESS,
  output logic [NUM_BTN-1:0] RELEASE,
  output logic               ANY_PRESS
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic               any_press_q;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];

  // State register: synchronizer, stable level, counters and output pulses.
  always_ff @(posedge C) begin
    if (CLR) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= BTN_RAW;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      any_press_q <= |press_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Next-state: idle when synced input matches the stable level, count while it differs,
  // accept on the last count. The counter never passes CntLast.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          level_d[i]   = sync2_q[i];
          press_d[i]   = sync2_q[i];
          release_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    BTN_LEVEL = level_q;
    PRESS     = press_q;
    RELEASE   = release_q;
    ANY_PRESS = any_press_q;
  end

endmodule

// File: tb/tb_finger_button_debounce.sv
// Bench for finger_button_debounce: directed scenarios plus random stimulus, checked every cycle
// against a window-based model of the debounce rule.
module tb_finger_button_debounce;

  localparam int NB = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          CLR = 1'b1;
  logic [NB-1:0] BTN_RAW = '0;
  logic [NB-1:0] BTN_LEVEL, PRESS, RELEASE;
  logic          ANY_PRESS;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  finger_button_debounce #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .C        (clk),
    .CLR      (CLR),
    .BTN_RAW  (BTN_RAW),
    .BTN_LEVEL(BTN_LEVEL),
    .PRESS    (PRESS),
    .RELEASE  (RELEASE),
    .ANY_PRESS(ANY_PRESS)
  );

  always #5 clk = ~clk;

  // Model: the value seen downstream is BTN_RAW delayed by two sampling edges. A pad flips when
  // the last D seen values all differ from its current level.
  logic [NB-1:0] dl[$];
  bit            win[NB][$];
  logic [NB-1:0] m_level = '0, m_press = '0, m_rel = '0;
  logic          m_any = 1'b0;

  initial dl = {4'b0, 4'b0};

  always @(posedge clk) begin
    logic [NB-1:0] seen;
    bit            differ;
    if (CLR) begin
      dl = {4'b0, 4'b0};
      for (int i = 0; i < NB; i++) win[i].delete();
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
    end else begin
      seen = dl.pop_front();
      dl.push_back(BTN_RAW);
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < NB; i++) begin
        win[i].push_back(seen[i]);
        if (win[i].size() > D) void'(win[i].pop_front());
        differ = (win[i].size() == D);
        foreach (win[i][j]) if (win[i][j] == m_level[i]) differ = 1'b0;
        if (differ) begin
          m_level[i] = ~m_level[i];
          m_press[i] = m_level[i];
          m_rel[i]   = ~m_level[i];
        end
      end
    end
    m_any = |m_press;
  end

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", BTN_LEVEL, m_level);
      chk("press", PRESS, m_press);
      chk("release", RELEASE, m_rel);
      chk("any_press", {3'b0, ANY_PRESS}, {3'b0, m_any});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int np, nr, nl;

  initial begin
    // Reset with all pads held, then the held pads come through as new presses.
    CLR = 1'b1;
    BTN_RAW = 4'b1111;
    step(1);
    chk_en = 1'b1;
    chk("rst_level", BTN_LEVEL, 4'b0000);
    chk("rst_press", PRESS, 4'b0000);
    step(2);
    chk("rst_any", {3'b0, ANY_PRESS}, 4'b0000);
    CLR = 1'b0;
    step(5);
    chk("post_rst_early", PRESS, 4'b0000);
    step(1);
    chk("post_rst_press", PRESS, 4'b1111);
    chk("post_rst_level", BTN_LEVEL, 4'b1111);
    chk("post_rst_model", m_press, 4'b1111);
    step(1);
    chk("post_rst_pulse_end", PRESS, 4'b0000);
    BTN_RAW = 4'b0000;
    step(12);
    chk("all_released", BTN_LEVEL, 4'b0000);

    // Clean press/release on pad 0.
    BTN_RAW[0] = 1'b1;
    step(5);
    chk("p0_early", PRESS, 4'b0000);
    step(1);
    chk("p0_press", PRESS, 4'b0001);
    chk("p0_any", {3'b0, ANY_PRESS}, 4'b0001);
    chk("p0_model", m_level, 4'b0001);
    step(14);
    BTN_RAW[0] = 1'b0;
    step(5);
    chk("p0_rel_early", RELEASE, 4'b0000);
    step(1);
    chk("p0_release", RELEASE, 4'b0001);
    chk("p0_level_low", BTN_LEVEL, 4'b0000);
    step(1);
    chk("p0_rel_end", RELEASE, 4'b0000);
    step(5);

    // Bounce on pad 1: only one press after it settles.
    np = 0;
    for (int k = 0; k < 5; k++) begin
      BTN_RAW[1] = (k % 2 == 0);
      for (int c = 0; c < 2; c++) begin
        step(1);
        np += int'(PRESS[1]);
      end
    end
    chk("bounce_quiet", np[NB-1:0], 4'd0);
    for (int c = 0; c < 12; c++) begin
      step(1);
      np += int'(PRESS[1]);
    end
    chk("bounce_one_press", np[NB-1:0], 4'd1);
    BTN_RAW[1] = 1'b0;
    step(10);

    // 3-cycle glitch on pad 2 is rejected.
    np = 0; nr = 0; nl = 0;
    BTN_RAW[2] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c == 3) BTN_RAW[2] = 1'b0;
      step(1);
      np += int'(PRESS[2]);
      nr += int'(RELEASE[2]);
      nl += int'(BTN_LEVEL[2]);
    end
    chk("glitch_press", np[NB-1:0], 4'd0);
    chk("glitch_release", nr[NB-1:0], 4'd0);
    chk("glitch_level", nl[NB-1:0], 4'd0);

    // Simultaneous presses on pads 1 and 3.
    BTN_RAW = 4'b1010;
    step(6);
    chk("simul_press", PRESS, 4'b1010);
    chk("simul_any", {3'b0, ANY_PRESS}, 4'b0001);
    step(1);
    chk("simul_pulse_end", PRESS, 4'b0000);
    chk("simul_any_end", {3'b0, ANY_PRESS}, 4'b0000);
    BTN_RAW = 4'b0000;
    step(12);

    // Reset mid-count on pad 3 while it stays held.
    BTN_RAW = 4'b1000;
    step(4);
    chk("midcnt_no_press", PRESS, 4'b0000);
    CLR = 1'b1;
    step(1);
    CLR = 1'b0;
    np = 0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      np += int'(PRESS[3]);
    end
    chk("midcnt_early", np[NB-1:0], 4'd0);
    step(1);
    chk("midcnt_press", PRESS, 4'b1000);
    BTN_RAW = 4'b0000;
    step(10);

    // Random stimulus with occasional resets.
    for (int s = 0; s < 400; s++) begin
      BTN_RAW = NB'($urandom);
      CLR = ($urandom_range(0, 39) == 0);
      step(1);
      CLR = 1'b0;
      step($urandom_range(0, 7));
    end
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/finger_button_debounce.md
Name: finger_button_debounce

Overview:
- Input conditioning stage for the finger pads. Sits directly upstream of the per-finger hit latch flip-flops.
- Takes raw, bouncy, asynchronous pad inputs and synchronizes them to the system clock.
- Debounces each pad independently.
- Produces a clean level plus one-cycle press/release pulses that drive the latch D/PRE inputs and the scoring logic.

Parameters:
- NUM_BTN, 4: number of independent pads (one per finger).
- DEBOUNCE_CYCLES, 250000: consecutive stable clocks required before accepting a change. Legal range is 2 or greater; the bench uses 4.
- CNT_W, clog2(DEBOUNCE_CYCLES+1): width of each per-pad stability counter.

Ports:
- C  input  1  system clock; all state updates on the rising edge.
- CLR  input  1  synchronous, active-high reset, sampled on the rising edge of C.
- BTN_RAW  input  NUM_BTN  raw pad inputs, asynchronous to C, active-high.
- BTN_LEVEL  output  NUM_BTN  debounced pad state, registered.
- PRESS  output  NUM_BTN  one-cycle pulse on a debounced 0->1 transition, registered.
- RELEASE  output  NUM_BTN  one-cycle pulse on a debounced 1->0 transition, registered.
- ANY_PRESS  output  1  OR of PRESS, registered in the same cycle as PRESS.

Behaviour:
- Interface: one clock, C. Reset CLR is synchronous and active-high. No asynchronous reset path exists in this block.
- Reset: an edge with CLR=1 clears, for every pad:
  - both synchronizer stages, stable state, and counter to 0;
  - BTN_LEVEL, PRESS, RELEASE and ANY_PRESS to 0.
  - CLR overrides all other activity, including a mid-count or a same-edge transition.
- Synchronizer: two-flop chain per pad (s1 <= BTN_RAW, s2 <= s1). Only s2 is used downstream.
- Per-pad state machine, with stable = BTN_LEVEL:
  - IDLE (s2 == stable): counter <= 0.
  - COUNTING (s2 != stable, counter < DEBOUNCE_CYCLES-1): counter <= counter+1.
  - ACCEPT (s2 != stable, counter == DEBOUNCE_CYCLES-1): stable <= s2 and counter <= 0. PRESS <= s2 and RELEASE <= ~s2 on that same edge.
  - Any edge where s2 returns to equal stable drops the pad back to IDLE and zeroes the counter. Glitches shorter than DEBOUNCE_CYCLES clocks are fully rejected.
- Pulses:
  - PRESS and RELEASE are high for exactly one cycle, then return to 0 on the next edge.
  - They are never both high for the same pad.
  - They rise in the same cycle BTN_LEVEL changes.
- Latency: the raw edge is first captured in s1 at edge E. BTN_LEVEL/PRESS update at edge E+1+DEBOUNCE_CYCLES, provided BTN_RAW is held throughout.
- Pads are fully independent. Simultaneous presses on several pads each produce their own PRESS in the same cycle. ANY_PRESS=1 if at least one pad's PRESS is 1.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- After CLR deasserts, a pad already held high is treated as a new press: the full debounce runs, then PRESS fires.

Test Plan:
- Reset and idle: CLR=1 for 3 edges with BTN_RAW=4'b1111, then CLR=0 -> all outputs 0 during reset. BTN_LEVEL=4'b1111 and PRESS=4'b1111 (single cycle) appear 1+4 edges after the first sampling edge following deassert.
- Clean press/release, pad 0 (DEBOUNCE_CYCLES=4): raise BTN_RAW[0] and hold 20 cycles, then drop -> PRESS[0] is a single-cycle pulse 5 edges after capture, and BTN_LEVEL[0]=1. RELEASE[0] is a single-cycle pulse 5 edges after the fall is captured. ANY_PRESS follows PRESS[0].
- Bounce rejection: toggle BTN_RAW[1] 1,0,1,0,1 with 2-cycle widths, then hold 1 -> no PRESS during the bounce. Exactly one PRESS[1] occurs 4 stable counts after the last rising capture.
- Glitch rejection: a 3-cycle high pulse on BTN_RAW[2] -> BTN_LEVEL[2], PRESS[2] and RELEASE[2] stay 0 throughout.
- Simultaneous pads: BTN_RAW 4'b0000->4'b1010 on one edge -> PRESS=4'b1010 in a single cycle and ANY_PRESS=1 for that cycle only.
- Reset mid-count: press pad 3, assert CLR after 2 counted cycles for 1 edge while the pad stays held -> no PRESS before reset, counter restarts from 0, and PRESS[3] fires exactly 1+4 edges after the first sampling edge following CLR deassert.
